fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 16: PC and instruction-memory address width.
REQ-002 Parameter DATA_W, default 32: instruction width; field positions fixed for 32.
REQ-003 CLK  in  1  single clock; all state changes on rising edge.
REQ-004 RST_F  in  1  reset, asynchronous, active-low.
REQ-005 PC_RST  in  1  synchronous PC clear request from control FSM.
REQ-006 PC_WRITE  in  1  launch fetch at current PC.
REQ-007 PC_SEL  in  1  take branch: load PC with branch target.
REQ-008 BR_SEL  in  1  branch kind: 1 absolute, 0 relative.
REQ-009 IMEM_REQ  out  1  instruction-memory read request, level.
REQ-010 IMEM_ADDR  out  ADDR_W  read address.
REQ-011 IMEM_RDATA  in  DATA_W  read data, sampled only with IMEM_VALID.
REQ-012 IMEM_VALID  in  1  read data valid, one-cycle pulse.
REQ-013 INSTR  out  DATA_W  instruction register.
REQ-014 OPCODE  out  4  INSTR[31:28].
REQ-015 MM  out  4  INSTR[27:24].
REQ-016 IMM  out  16  INSTR[15:0].
REQ-017 PC  out  ADDR_W  address of next instruction to fetch.
REQ-018 CUR_PC  out  ADDR_W  address of instruction held in INSTR.
REQ-019 IR_VALID  out  1  INSTR holds a completed fetch.
REQ-020 HALTED  out  1  HLT (opcode 15) captured; fetching stopped.

Function
REQ-021 FSM states IDLE, WAIT, READY, HALT; encoding from shared package.
REQ-022 IDLE or READY, PC_WRITE=1, PC_SEL=0, PC_RST=0 -> WAIT next cycle; IMEM_REQ=1, IMEM_ADDR=PC registered at that edge.
REQ-023 WAIT: IMEM_REQ and IMEM_ADDR held stable until IMEM_VALID sampled high; PC_WRITE, PC_SEL ignored.
REQ-024 WAIT with IMEM_VALID=1: INSTR<=IMEM_RDATA, CUR_PC<=PC, PC<=PC+1 (mod 2^ADDR_W), IMEM_REQ<=0, IR_VALID<=1, state READY; fields valid the cycle after VALID.
REQ-025 Captured opcode 15 -> state HALT, HALTED=1; PC still increments; no further IMEM_REQ until reset.
REQ-026 READY with PC_SEL=1: BR_SEL=1 -> PC<=zero-extended IMM truncated to ADDR_W; BR_SEL=0 -> PC<=CUR_PC+sign-extended IMM, wrap mod 2^ADDR_W.
REQ-027 PC_SEL and PC_WRITE same cycle in READY: branch only; fetch not launched; PC_WRITE must be reasserted.
REQ-028 PC_SEL outside READY ignored.
REQ-029 PC_RST=1 in any state except HALT: PC<=0, CUR_PC<=0, IR_VALID<=0, IMEM_REQ<=0, state IDLE; pending request abandoned; priority over all other inputs.
REQ-030 IMEM_VALID outside WAIT ignored, including late response of abandoned request.
REQ-031 INSTR, OPCODE, MM, IMM unchanged except at capture (REQ-024) and reset.
REQ-032 PC at 2^ADDR_W-1 increments to 0 without flag.

Reset
REQ-033 RST_F low, asynchronously: state IDLE, PC=0, CUR_PC=0, INSTR=0, IMEM_REQ=0, IMEM_ADDR=0, IR_VALID=0, HALTED=0.
REQ-034 RST_F low mid-WAIT abandons request; first cycle after release is IDLE.
REQ-035 HALT exits only via RST_F.

Structure
REQ-036 Shared package cpu_pkg: state encoding, opcode constants (NOOP 0, LOD 1, STR 2, BRA 4, BRR 5, BNE 6, ALU 8, HLT 15), field bit positions.
REQ-037 One sub-module fetch_pc_next: combinational next-PC select (increment, absolute, relative); all registers in fetch_unit.

Verification
REQ-038 Reset release, PC_WRITE pulse, VALID 3 cycles after IMEM_REQ with 0x8100_0005 -> IMEM_ADDR=0, OPCODE=8, MM=1, IMM=5, CUR_PC=0, PC=1, IR_VALID=1.
REQ-039 CUR_PC=0x0010, IMM=0xFFFC, PC_SEL=1, BR_SEL=0 -> PC=0x000C; IMM=0x0040, BR_SEL=1 -> PC=0x0040.
REQ-040 PC_RST=1 during WAIT, VALID arrives 2 cycles later -> IMEM_REQ=0 next cycle, INSTR unchanged, PC=0, IR_VALID=0.
REQ-041 Fetch 0xF000_0000 -> HALTED=1, state HALT; further PC_WRITE and PC_RST produce no IMEM_REQ; RST_F low clears.
REQ-042 PC=0xFFFF, fetch completes -> PC=0x0000, CUR_PC=0xFFFF.
REQ-043 PC_WRITE and PC_SEL together in READY -> PC updated to target, no IMEM_REQ that cycle or next.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, opcode values, instruction field
// positions and the next-PC select codes used by the fetch path.
package cpu_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   localparam logic [3:0] OP_NOOP = 4'd0;
   localparam logic [3:0] OP_LOD  = 4'd1;
   localparam logic [3:0] OP_STR  = 4'd2;
   localparam logic [3:0] OP_BRA  = 4'd4;
   localparam logic [3:0] OP_BRR  = 4'd5;
   localparam logic [3:0] OP_BNE  = 4'd6;
   localparam logic [3:0] OP_ALU  = 4'd8;
   localparam logic [3:0] OP_HLT  = 4'd15;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 28;
   localparam int MM_MSB  = 27;
   localparam int MM_LSB  = 24;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   localparam logic [1:0] PCN_INC = 2'd0;
   localparam logic [1:0] PCN_ABS = 2'd1;
   localparam logic [1:0] PCN_REL = 2'd2;

   function automatic logic is_halt(input logic [3:0] opcode);
      return (opcode == OP_HLT);
   endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC selection: sequential increment, absolute branch
// (zero-extended immediate) or PC-relative branch (sign-extended immediate).
module fetch_pc_next
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic [1:0]        i_sel,
   input  logic [ADDR_W-1:0] i_pc,
   input  logic [ADDR_W-1:0] i_cur_pc,
   input  logic [15:0]       i_imm,
   output logic [ADDR_W-1:0] o_next_pc
);

   logic [ADDR_W-1:0] w_one;
   logic [ADDR_W-1:0] w_imm_zx;
   logic [ADDR_W-1:0] w_imm_sx;

   assign w_one    = ADDR_W'(1);
   assign w_imm_zx = ADDR_W'(i_imm);
   assign w_imm_sx = ADDR_W'($signed(i_imm));

   // All three sums wrap naturally at the address width.
   always_comb begin
      o_next_pc = i_pc + w_one;
      case (i_sel)
         PCN_ABS: o_next_pc = w_imm_zx;
         PCN_REL: o_next_pc = i_cur_pc + w_imm_sx;
         default: o_next_pc = i_pc + w_one;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory read per PC_WRITE,
// captures the returned word, exposes decoded fields and handles branches/halt.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_f,
   input  logic              i_pc_rst,
   input  logic              i_pc_write,
   input  logic              i_pc_sel,
   input  logic              i_br_sel,
   output logic              o_imem_req,
   output logic [ADDR_W-1:0] o_imem_addr,
   input  logic [DATA_W-1:0] i_imem_rdata,
   input  logic              i_imem_valid,
   output logic [DATA_W-1:0] o_instr,
   output logic [3:0]        o_opcode,
   output logic [3:0]        o_mm,
   output logic [15:0]       o_imm,
   output logic [ADDR_W-1:0] o_pc,
   output logic [ADDR_W-1:0] o_cur_pc,
   output logic              o_ir_valid,
   output logic              o_halted
);

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_cur_pc;
   logic [DATA_W-1:0] r_instr;
   logic              r_imem_req;
   logic [ADDR_W-1:0] r_imem_addr;
   logic              r_ir_valid;
   logic              r_halted;

   logic              w_take_branch;
   logic              w_launch;
   logic [1:0]        w_pcn_sel;
   logic [ADDR_W-1:0] w_next_pc;

   // A branch request wins over a simultaneous fetch launch; launch needs PC_SEL low.
   assign w_take_branch = (r_state == ST_READY) && i_pc_sel;
   assign w_launch      = ((r_state == ST_IDLE) || (r_state == ST_READY)) &&
                          i_pc_write && !i_pc_sel;
   assign w_pcn_sel     = w_take_branch ? (i_br_sel ? PCN_ABS : PCN_REL) : PCN_INC;

   fetch_pc_next #(
      .ADDR_W (ADDR_W)
   ) u_pc_next (
      .i_sel     (w_pcn_sel),
      .i_pc      (r_pc),
      .i_cur_pc  (r_cur_pc),
      .i_imm     (r_instr[IMM_MSB:IMM_LSB]),
      .o_next_pc (w_next_pc)
   );

   always_ff @(posedge i_clk or negedge i_rst_f) begin
      if (!i_rst_f) begin
         r_state     <= ST_IDLE;
         r_pc        <= '0;
         r_cur_pc    <= '0;
         r_instr     <= '0;
         r_imem_req  <= 1'b0;
         r_imem_addr <= '0;
         r_ir_valid  <= 1'b0;
         r_halted    <= 1'b0;
      end else if (i_pc_rst && (r_state != ST_HALT)) begin
         // Abandons any outstanding read; a late VALID is then ignored in IDLE.
         r_state    <= ST_IDLE;
         r_pc       <= '0;
         r_cur_pc   <= '0;
         r_imem_req <= 1'b0;
         r_ir_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_READY: begin
               if (w_take_branch) begin
                  r_pc <= w_next_pc;
               end else if (w_launch) begin
                  r_imem_req  <= 1'b1;
                  r_imem_addr <= r_pc;
                  r_state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (i_imem_valid) begin
                  r_instr    <= i_imem_rdata;
                  r_cur_pc   <= r_pc;
                  r_pc       <= w_next_pc;
                  r_imem_req <= 1'b0;
                  r_ir_valid <= 1'b1;
                  if (is_halt(i_imem_rdata[OPC_MSB:OPC_LSB])) begin
                     r_state  <= ST_HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_state <= ST_READY;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_imem_req  = r_imem_req;
   assign o_imem_addr = r_imem_addr;
   assign o_instr     = r_instr;
   assign o_opcode    = r_instr[OPC_MSB:OPC_LSB];
   assign o_mm        = r_instr[MM_MSB:MM_LSB];
   assign o_imm       = r_instr[IMM_MSB:IMM_LSB];
   assign o_pc        = r_pc;
   assign o_cur_pc    = r_cur_pc;
   assign o_ir_valid  = r_ir_valid;
   assign o_halted    = r_halted;

endmodule
